// File: rtl/flac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : flac_pkg
// Purpose  : Shared constants, types and helpers for the FLAC residual stage
//            (variable_rice_encoder -> rice_writer).
// Contents : DATA_W/ADDR_W/MAX_CW, Rice-parameter width, packer datapath
//            widths, RAM write-port record, zigzag mapping helper.
// Revision : 1.0 - initial release
// ============================================================================
package flac_pkg;

  localparam int DATA_W   = 16;          // RAM word width, MSB is first stream bit
  localparam int ADDR_W   = 16;          // RAM address width
  localparam int MAX_CW   = 32;          // largest legal codeword length
  localparam int PARAM_W  = 4;           // Rice parameter width
  localparam int CW_W     = 16;          // width of iTotal/iUpper/iLower
  localparam int STREAM_W = 3 * DATA_W;  // residual + worst-case codeword fits
  localparam int CNT_W    = 4;           // residual bit count, 0..DATA_W-1
  localparam int LEN_W    = 6;           // bit counts up to STREAM_W-1

  // One registered RAM write port.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } ram_wr_t;

  // Signed sample to unsigned Rice index: s>=0 -> 2s, s<0 -> -2s-1.
  // For negative s, -2s-1 == ~(2s) in two's complement.
  function automatic logic [CW_W-1:0] zigzag(input logic signed [CW_W-1:0] s);
    logic [CW_W-1:0] dbl;
    dbl = {s[CW_W-2:0], 1'b0};
    return s[CW_W-1] ? ~dbl : dbl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rice_writer_if.sv
`default_nettype none
// ============================================================================
// Module   : rice_writer_if
// Purpose  : Command bus into rice_writer and its two RAM write ports.
// Ports    : iEnable/iTotal/iUpper/iLower/iRiceParam/iChangeParam/iFlush
//            (producer -> writer), oRamEnable1/2, oRamAddress1/2,
//            oRamData1/2 (writer -> RAM).
//            master : producer side (drives commands, sees RAM writes)
//            slave  : rice_writer side
// Revision : 1.0 - initial release
// ============================================================================
interface rice_writer_if;
  import flac_pkg::*;

  logic               iEnable;
  logic [CW_W-1:0]    iTotal;
  logic [CW_W-1:0]    iUpper;
  logic [CW_W-1:0]    iLower;
  logic [PARAM_W-1:0] iRiceParam;
  logic               iChangeParam;
  logic               iFlush;

  logic               oRamEnable1;
  logic [ADDR_W-1:0]  oRamAddress1;
  logic [DATA_W-1:0]  oRamData1;
  logic               oRamEnable2;
  logic [ADDR_W-1:0]  oRamAddress2;
  logic [DATA_W-1:0]  oRamData2;

  modport master (
    output iEnable, iTotal, iUpper, iLower, iRiceParam, iChangeParam, iFlush,
    input  oRamEnable1, oRamAddress1, oRamData1,
    input  oRamEnable2, oRamAddress2, oRamData2
  );

  modport slave (
    input  iEnable, iTotal, iUpper, iLower, iRiceParam, iChangeParam, iFlush,
    output oRamEnable1, oRamAddress1, oRamData1,
    output oRamEnable2, oRamAddress2, oRamData2
  );

endinterface
`default_nettype wire

// File: rtl/variable_rice_encoder.sv
`default_nettype none
// ============================================================================
// Module   : variable_rice_encoder
// Purpose  : Rice-codes one signed residual per valid cycle with parameter k.
//            Fixed 2-cycle latency from iValid to oValid.
// Ports    : iClock, iReset (async, active-low), iValid, iSample[15:0],
//            iRiceParam[3:0]; oMSB = q = u>>k, oLSB = {1, u[k-1:0]},
//            oBitsUsed = q+1+k, oValid.
// Revision : 1.0 - initial release
// ============================================================================
module variable_rice_encoder
  import flac_pkg::*;
(
  input  logic                      iClock,
  input  logic                      iReset,
  input  logic                      iValid,
  input  logic signed [CW_W-1:0]    iSample,
  input  logic        [PARAM_W-1:0] iRiceParam,
  output logic        [CW_W-1:0]    oMSB,
  output logic        [CW_W-1:0]    oLSB,
  output logic        [CW_W-1:0]    oBitsUsed,
  output logic                      oValid
);

  // Stage 1: zigzag index and parameter.
  logic               valid1_q;
  logic [CW_W-1:0]    u_q;
  logic [PARAM_W-1:0] k_q;

  // Stage 2: coded fields.
  logic               valid2_q;
  logic [CW_W-1:0]    msb_q, lsb_q, bits_q;

  logic [CW_W-1:0]    q_d, lsb_d, bits_d;

  always_comb begin
    q_d    = u_q >> k_q;
    // Keep u[k-1:0] and set the stop bit at position k.
    lsb_d  = (u_q & ~({CW_W{1'b1}} << k_q)) | ({{(CW_W-1){1'b0}}, 1'b1} << k_q);
    bits_d = q_d + {{(CW_W-PARAM_W){1'b0}}, k_q} + {{(CW_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      valid1_q <= 1'b0;
      u_q      <= '0;
      k_q      <= '0;
      valid2_q <= 1'b0;
      msb_q    <= '0;
      lsb_q    <= '0;
      bits_q   <= '0;
    end else begin
      valid1_q <= iValid;
      u_q      <= zigzag(iSample);
      k_q      <= iRiceParam;
      valid2_q <= valid1_q;
      msb_q    <= q_d;
      lsb_q    <= lsb_d;
      bits_q   <= bits_d;
    end
  end

  assign oMSB      = msb_q;
  assign oLSB      = lsb_q;
  assign oBitsUsed = bits_q;
  assign oValid    = valid2_q;

endmodule
`default_nettype wire

// File: rtl/rice_writer.sv
`default_nettype none
// ============================================================================
// Module   : rice_writer
// Purpose  : Packs Rice codewords / 4-bit parameters MSB-first into a
//            continuous bit stream and writes each completed 16-bit word to
//            RAM, up to two words per cycle, with 1 cycle registered latency.
// Ports    : iClock, iReset (async, active-low),
//            bus (rice_writer_if.slave): command inputs and the two RAM
//            write ports (port 2 = address of port 1 + 1, only with port 1).
// Revision : 1.0 - initial release
// ============================================================================
module rice_writer
  import flac_pkg::*;
(
  input  logic         iClock,
  input  logic         iReset,
  rice_writer_if.slave bus
);

  localparam logic [LEN_W-1:0] C_QMAX = LEN_W'(MAX_CW - 1);

  // Pending bits are left-justified in r_q; bits below the count are zero.
  logic [DATA_W-1:0] r_q, r_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] a_q;
  ram_wr_t           port1_q, port2_q;

  logic [PARAM_W-1:0]  k;
  logic [PARAM_W:0]    kp1;
  logic [LEN_W-1:0]    q_lim, q_eff, cw_len;
  logic                clamp;
  logic [CW_W-1:0]     lower_m, val;
  logic [LEN_W-1:0]    len, total, padded;
  logic [6:0]          shamt;
  logic [STREAM_W-1:0] stream;
  logic [1:0]          words;

  always_comb begin
    k     = bus.iRiceParam;
    kp1   = {1'b0, k} + 5'd1;

    // Oversized codewords shrink their zero run so q+1+k == MAX_CW; the
    // iUpper check keeps the datapath safe even if iTotal disagrees.
    q_lim  = C_QMAX - {{(LEN_W-PARAM_W){1'b0}}, k};
    clamp  = (bus.iTotal > CW_W'(MAX_CW)) ||
             (bus.iUpper > {{(CW_W-LEN_W){1'b0}}, q_lim});
    q_eff  = clamp ? q_lim : bus.iUpper[LEN_W-1:0];
    cw_len = q_eff + {1'b0, kp1};

    // Only the low k+1 bits of iLower are meaningful; the leading q zeros
    // come for free from the right-aligned value.
    lower_m = bus.iLower & ~({CW_W{1'b1}} << kp1);

    if (bus.iChangeParam) begin
      val = {{(CW_W-PARAM_W){1'b0}}, k};
      len = LEN_W'(PARAM_W);
    end else if (!bus.iFlush) begin
      val = lower_m;
      len = cw_len;
    end else begin
      val = '0;
      len = '0;
    end

    // Merge: new bits land immediately after the pending residual.
    total  = {{(LEN_W-CNT_W){1'b0}}, cnt_q} + len;
    shamt  = 7'(STREAM_W) - {1'b0, total};
    stream = {r_q, {(2*DATA_W){1'b0}}} | ({{(STREAM_W-CW_W){1'b0}}, val} << shamt);

    // Flush rounds up to the next word; an empty residual needs no pad.
    if (bus.iFlush && (total[3:0] != 4'd0))
      padded = {total[5:4] + 2'd1, 4'd0};
    else
      padded = total;

    words = padded[5:4];
    cnt_d = padded[3:0];

    case (words)
      2'd0:    r_d = stream[47:32];
      2'd1:    r_d = stream[31:16];
      default: r_d = stream[15:0];
    endcase
  end

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      r_q     <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      port1_q <= '0;
      port2_q <= '0;
    end else if (bus.iEnable) begin
      r_q        <= r_d;
      cnt_q      <= cnt_d;
      a_q        <= a_q + {{(ADDR_W-2){1'b0}}, words};
      port1_q.en <= (words != 2'd0);
      port2_q.en <= (words == 2'd2);
      if (words != 2'd0) begin
        port1_q.addr <= a_q;
        port1_q.data <= stream[47:32];
      end
      if (words == 2'd2) begin
        port2_q.addr <= a_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        port2_q.data <= stream[31:16];
      end
    end else begin
      port1_q.en <= 1'b0;
      port2_q.en <= 1'b0;
    end
  end

  assign bus.oRamEnable1  = port1_q.en;
  assign bus.oRamAddress1 = port1_q.addr;
  assign bus.oRamData1    = port1_q.data;
  assign bus.oRamEnable2  = port2_q.en;
  assign bus.oRamAddress2 = port2_q.addr;
  assign bus.oRamData2    = port2_q.data;

endmodule
`default_nettype wire

// File: tb/tb_rice_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_rice_writer
// Purpose  : Directed self-checking bench: variable_rice_encoder feeding
//            rice_writer, plus direct command vectors into the writer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rice_writer;
  import flac_pkg::*;

  logic iClock = 1'b0;
  logic iReset = 1'b0;
  always #5 iClock = ~iClock;

  int checks = 0;
  int errors = 0;

  // Direct command drive.
  logic        tb_en = 1'b0, tb_cp = 1'b0, tb_fl = 1'b0;
  logic [3:0]  tb_k = 4'd0;
  logic [15:0] tb_up = '0, tb_lo = '0, tb_tot = '0;

  // Encoder path.
  logic               use_enc = 1'b0;
  logic               enc_in_valid = 1'b0;
  logic signed [15:0] enc_sample = '0;
  logic [15:0]        enc_msb, enc_lsb, enc_bits;
  logic               enc_valid;

  rice_writer_if bus();

  variable_rice_encoder u_enc (
    .iClock     (iClock),
    .iReset     (iReset),
    .iValid     (enc_in_valid),
    .iSample    (enc_sample),
    .iRiceParam (tb_k),
    .oMSB       (enc_msb),
    .oLSB       (enc_lsb),
    .oBitsUsed  (enc_bits),
    .oValid     (enc_valid)
  );

  rice_writer dut (
    .iClock (iClock),
    .iReset (iReset),
    .bus    (bus)
  );

  assign bus.iEnable      = use_enc ? enc_valid : tb_en;
  assign bus.iUpper       = use_enc ? enc_msb   : tb_up;
  assign bus.iLower       = use_enc ? enc_lsb   : tb_lo;
  assign bus.iTotal       = use_enc ? enc_bits  : tb_tot;
  assign bus.iChangeParam = use_enc ? 1'b0      : tb_cp;
  assign bus.iFlush       = use_enc ? 1'b0      : tb_fl;
  assign bus.iRiceParam   = tb_k;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // One enabled writer cycle; returns #1 after the consuming edge.
  task automatic step(input logic cp, input logic fl, input logic [3:0] k,
                      input logic [15:0] up, input logic [15:0] lo, input logic [15:0] tot);
    tb_en = 1'b1; tb_cp = cp; tb_fl = fl; tb_k = k;
    tb_up = up;   tb_lo = lo; tb_tot = tot;
    @(posedge iClock); #1;
    tb_en = 1'b0; tb_cp = 1'b0; tb_fl = 1'b0;
  endtask

  // One sample through the encoder, then the writer cycle that consumes it.
  task automatic enc(input logic signed [15:0] s, input logic [15:0] e_msb,
                     input logic [15:0] e_lsb, input logic [15:0] e_bits,
                     input logic e_en1, input logic [15:0] e_data1);
    use_enc = 1'b1; enc_in_valid = 1'b1; enc_sample = s;
    @(posedge iClock); #1;
    enc_in_valid = 1'b0;
    @(posedge iClock); #1;
    chk("enc_valid", enc_valid, 1'b1);
    chk("enc_msb",   enc_msb,   e_msb);
    chk("enc_lsb",   enc_lsb,   e_lsb);
    chk("enc_bits",  enc_bits,  e_bits);
    @(posedge iClock); #1;
    chk("enc_wr_en1",  bus.oRamEnable1, e_en1);
    chk("enc_wr_data", bus.oRamData1,   e_data1);
  endtask

  initial begin
    // Reset state.
    repeat (2) @(posedge iClock);
    #1;
    chk("rst_en1",   bus.oRamEnable1,  1'b0);
    chk("rst_addr1", bus.oRamAddress1, 16'h0);
    chk("rst_data1", bus.oRamData1,    16'h0);
    chk("rst_en2",   bus.oRamEnable2,  1'b0);
    chk("rst_addr2", bus.oRamAddress2, 16'h0);
    chk("rst_data2", bus.oRamData2,    16'h0);
    iReset = 1'b1;
    @(posedge iClock); #1;

    // k=7 param, samples 0 and 1 as direct codewords, then flush.
    step(1, 0, 4'd7, 16'd0, 16'h0000, 16'd0);
    chk("p7_en1", bus.oRamEnable1, 1'b0);
    step(0, 0, 4'd7, 16'd0, 16'h0080, 16'd8);
    chk("s0_en1", bus.oRamEnable1, 1'b0);
    step(0, 0, 4'd7, 16'd0, 16'h0082, 16'd8);
    chk("s1_en1",   bus.oRamEnable1,  1'b1);
    chk("s1_addr1", bus.oRamAddress1, 16'd0);
    chk("s1_data1", bus.oRamData1,    16'h7808);
    chk("s1_en2",   bus.oRamEnable2,  1'b0);
    step(0, 1, 4'd7, 16'd0, 16'h0, 16'd0);
    chk("fl1_en1",   bus.oRamEnable1,  1'b1);
    chk("fl1_addr1", bus.oRamAddress1, 16'd1);
    chk("fl1_data1", bus.oRamData1,    16'h2000);
    chk("fl1_en2",   bus.oRamEnable2,  1'b0);

    // Idle: strobes drop, data/address hold.
    @(posedge iClock); #1;
    chk("idle_en1",   bus.oRamEnable1,  1'b0);
    chk("idle_addr1", bus.oRamAddress1, 16'd1);
    chk("idle_data1", bus.oRamData1,    16'h2000);

    // Encoder-driven: param 0111, then -1, -64, 200 at k=7.
    step(1, 0, 4'd7, 16'd0, 16'h0, 16'd0);
    enc(-16'sd1,  16'd0, 16'h0081, 16'd8,  1'b0, 16'h2000);
    enc(-16'sd64, 16'd0, 16'h00FF, 16'd8,  1'b1, 16'h781F);
    chk("enc_wr_addr", bus.oRamAddress1, 16'd2);
    enc(16'sd200, 16'd3, 16'h0090, 16'd11, 1'b0, 16'h781F);
    use_enc = 1'b0;
    step(0, 1, 4'd7, 16'd0, 16'h0, 16'd0);
    chk("fl2_en1",   bus.oRamEnable1,  1'b1);
    chk("fl2_addr1", bus.oRamAddress1, 16'd3);
    chk("fl2_data1", bus.oRamData1,    16'hF120);

    // Flush on empty residual: no strobe.
    step(0, 1, 4'd7, 16'd0, 16'h0, 16'd0);
    chk("fle_en1", bus.oRamEnable1, 1'b0);
    chk("fle_en2", bus.oRamEnable2, 1'b0);

    // ChangeParam + Flush with empty residual: one word 0x5000 at A=4.
    step(1, 1, 4'd5, 16'd0, 16'h0, 16'd0);
    chk("cpf_en1",   bus.oRamEnable1,  1'b1);
    chk("cpf_addr1", bus.oRamAddress1, 16'd4);
    chk("cpf_data1", bus.oRamData1,    16'h5000);
    chk("cpf_en2",   bus.oRamEnable2,  1'b0);

    // Double word: 0100 + 27 zeros + 11111 (32-bit codeword, junk upper iLower bits).
    step(1, 0, 4'd4, 16'd0, 16'h0, 16'd0);
    chk("p4_en1", bus.oRamEnable1, 1'b0);
    step(0, 0, 4'd4, 16'd27, 16'hFFFF, 16'd32);
    chk("dw_en1",   bus.oRamEnable1,  1'b1);
    chk("dw_addr1", bus.oRamAddress1, 16'd5);
    chk("dw_data1", bus.oRamData1,    16'h4000);
    chk("dw_en2",   bus.oRamEnable2,  1'b1);
    chk("dw_addr2", bus.oRamAddress2, 16'd6);
    chk("dw_data2", bus.oRamData2,    16'h0001);
    step(0, 1, 4'd4, 16'd0, 16'h0, 16'd0);
    chk("fl3_en1",   bus.oRamEnable1,  1'b1);
    chk("fl3_addr1", bus.oRamAddress1, 16'd7);
    chk("fl3_data1", bus.oRamData1,    16'hF000);
    chk("fl3_en2",   bus.oRamEnable2,  1'b0);

    // Oversized codeword (total 41, k=0): clamped to 31 zeros + '1'.
    step(0, 0, 4'd0, 16'd40, 16'h0001, 16'd41);
    chk("clp_en1",   bus.oRamEnable1,  1'b1);
    chk("clp_addr1", bus.oRamAddress1, 16'd8);
    chk("clp_data1", bus.oRamData1,    16'h0000);
    chk("clp_en2",   bus.oRamEnable2,  1'b1);
    chk("clp_addr2", bus.oRamAddress2, 16'd9);
    chk("clp_data2", bus.oRamData2,    16'h0001);
    step(0, 1, 4'd0, 16'd0, 16'h0, 16'd0);
    chk("clp_fl_en1", bus.oRamEnable1, 1'b0);

    // Mid-stream asynchronous reset with residual 0011 pending.
    step(1, 0, 4'd3, 16'd0, 16'h0, 16'd0);
    chk("p3_en1", bus.oRamEnable1, 1'b0);
    iReset = 1'b0;
    #1;
    chk("mrst_addr1", bus.oRamAddress1, 16'd0);
    chk("mrst_addr2", bus.oRamAddress2, 16'd0);
    chk("mrst_data2", bus.oRamData2,    16'd0);
    chk("mrst_en1",   bus.oRamEnable1,  1'b0);
    @(negedge iClock);
    iReset = 1'b1;
    @(posedge iClock); #1;
    step(1, 1, 4'd9, 16'd0, 16'h0, 16'd0);
    chk("post_en1",   bus.oRamEnable1,  1'b1);
    chk("post_addr1", bus.oRamAddress1, 16'd0);
    chk("post_data1", bus.oRamData1,    16'h9000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
